// File: rtl/fft_result_streamer_if.sv
// fft_result_streamer_if
// Byte-stream channel between fft_result_streamer and its consumer.
//   out_valid : out_data/out_bin/out_last hold a byte for the consumer
//   out_data  : current byte (re, im or approximate magnitude)
//   out_bin   : bin index 0..3 of the current byte
//   out_last  : current byte is the final byte of the frame
//   out_ready : consumer accepts the current byte
// The master modport is the streamer and the slave modport is the consumer.
interface fft_result_streamer_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_bin;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_bin,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_bin,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_result_streamer.sv
// fft_result_streamer
// Captures the four bins of the 4-point FFT engine when it signals done. The
// bins are sent as a byte stream over a valid/ready handshake in the order
// bin0..bin3. Each bin is sent as re, im and, when EMIT_MAG is set, a
// magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : global enable; all state holds while low
//   done_in      : one-cycle pulse, freq*_in valid this cycle
//   freq0..3_in  : bins as {re[7:0], im[7:0]}, two's complement
//   clr_err      : clears overflow_err (a drop in the same cycle wins)
//   stream       : byte stream (out_valid/out_data/out_bin/out_last/out_ready)
//   busy         : a frame is buffered or streaming
//   frame_done   : one-cycle pulse after the frame's last byte is accepted
//   overflow_err : sticky, a frame arrived while streaming and was dropped
module fft_result_streamer #(
    parameter bit EMIT_MAG = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         done_in,
    input  logic [15:0]                  freq0_in,
    input  logic [15:0]                  freq1_in,
    input  logic [15:0]                  freq2_in,
    input  logic [15:0]                  freq3_in,
    input  logic                         clr_err,
    fft_result_streamer_if.master        stream,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow_err
);

    // Index of the last byte within one bin.
    localparam logic [1:0] LastByte = EMIT_MAG ? 2'd2 : 2'd1;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e     state_q, state_d;
    logic [7:0] re_q [4];
    logic [7:0] re_d [4];
    logic [7:0] im_q [4];
    logic [7:0] im_d [4];
    logic [1:0] bin_q, bin_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] data_q, data_d;
    logic [1:0] obin_q, obin_d;
    logic       last_q, last_d;
    logic       frame_done_q, frame_done_d;
    logic       overflow_q, overflow_d;

    logic       hs;
    logic       at_last;
    logic       last_hs;
    logic       capture;
    logic       drop;

    // |v| as an 8-bit unsigned value; -128 maps to 128.
    function automatic logic [7:0] abs8(input logic [7:0] v);
        return v[7] ? (~v + 8'd1) : v;
    endfunction

    function automatic logic [7:0] mag8(input logic [7:0] re, input logic [7:0] im);
        logic [7:0] a;
        logic [7:0] b;
        a = abs8(re);
        b = abs8(im);
        // Largest result is 128 + 64 = 192, so 8 bits never overflow.
        return (a > b) ? (a + (b >> 1)) : (b + (a >> 1));
    endfunction

    // Byte drawn from the registered buffer, never from the live inputs.
    function automatic logic [7:0] sel_byte(input logic [1:0] bin, input logic [1:0] idx,
                                            input logic [7:0] re [4],
                                            input logic [7:0] im [4]);
        logic [7:0] r;
        unique case (idx)
            2'd0:    r = re[bin];
            2'd1:    r = im[bin];
            default: r = mag8(re[bin], im[bin]);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        re_d         = re_q;
        im_d         = im_q;
        bin_d        = bin_q;
        byte_d       = byte_q;
        data_d       = data_q;
        obin_d       = obin_q;
        last_d       = last_q;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q;

        hs      = (state_q == StStream) & stream.out_ready;
        at_last = (bin_q == 2'd3) & (byte_q == LastByte);
        last_hs = hs & at_last;
        // A new frame fits only if the buffer is free or being freed now.
        capture = done_in & ((state_q == StIdle) | last_hs);
        drop    = done_in & (state_q == StStream) & ~last_hs;

        if (ena) begin
            frame_done_d = last_hs;

            if (drop) begin
                overflow_d = 1'b1;
            end else if (clr_err) begin
                overflow_d = 1'b0;
            end

            if (capture) begin
                state_d = StStream;
                re_d[0] = freq0_in[15:8];
                im_d[0] = freq0_in[7:0];
                re_d[1] = freq1_in[15:8];
                im_d[1] = freq1_in[7:0];
                re_d[2] = freq2_in[15:8];
                im_d[2] = freq2_in[7:0];
                re_d[3] = freq3_in[15:8];
                im_d[3] = freq3_in[7:0];
                bin_d   = 2'd0;
                byte_d  = 2'd0;
                data_d  = freq0_in[15:8];
                obin_d  = 2'd0;
                last_d  = 1'b0;
            end else if (last_hs) begin
                // Counters stay parked at the frame end until the next capture.
                state_d = StIdle;
            end else if (hs) begin
                if (byte_q == LastByte) begin
                    byte_d = 2'd0;
                    bin_d  = bin_q + 2'd1;
                end else begin
                    byte_d = byte_q + 2'd1;
                end
                data_d = sel_byte(bin_d, byte_d, re_q, im_q);
                obin_d = bin_d;
                last_d = (bin_d == 2'd3) & (byte_d == LastByte);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            for (int i = 0; i < 4; i++) begin
                re_q[i] <= 8'd0;
                im_q[i] <= 8'd0;
            end
            bin_q        <= 2'd0;
            byte_q       <= 2'd0;
            data_q       <= 8'd0;
            obin_q       <= 2'd0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            re_q         <= re_d;
            im_q         <= im_d;
            bin_q        <= bin_d;
            byte_q       <= byte_d;
            data_q       <= data_d;
            obin_q       <= obin_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign stream.out_valid = (state_q == StStream);
    assign stream.out_data  = data_q;
    assign stream.out_bin   = obin_q;
    assign stream.out_last  = last_q;
    assign busy             = (state_q == StStream);
    assign frame_done       = frame_done_q;
    assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer
// Drives one stimulus stream into two streamers (EMIT_MAG = 1 and 0). On each
// accepted frame the expected bytes are pushed into a per-instance queue; a
// negedge monitor pops and compares whenever a handshake is due and checks
// the status flags against a frame-level model.
module tb_fft_result_streamer;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] b;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        done_in = 1'b0;
    logic        clr_err = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] f0 = 16'h0, f1 = 16'h0, f2 = 16'h0, f3 = 16'h0;
    logic        busy0, busy1, fd0, fd1, ovf0, ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Frame-level model: busy flag, bytes left in the frame, flags.
    bit m_busy[2];
    int m_left[2];
    bit m_fd[2];
    bit m_ovf[2];
    bit stall_v[2];
    logic [9:0] stall_d[2];

    always #5 clk = ~clk;

    fft_result_streamer_if sif0 ();
    fft_result_streamer_if sif1 ();
    assign sif0.out_ready = out_ready;
    assign sif1.out_ready = out_ready;

    fft_result_streamer #(.EMIT_MAG(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .done_in(done_in),
        .freq0_in(f0), .freq1_in(f1), .freq2_in(f2), .freq3_in(f3),
        .clr_err(clr_err), .stream(sif0),
        .busy(busy0), .frame_done(fd0), .overflow_err(ovf0)
    );

    fft_result_streamer #(.EMIT_MAG(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .done_in(done_in),
        .freq0_in(f0), .freq1_in(f1), .freq2_in(f2), .freq3_in(f3),
        .clr_err(clr_err), .stream(sif1),
        .busy(busy1), .frame_done(fd1), .overflow_err(ovf1)
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int abs8(input logic [7:0] v);
        int s;
        s = $signed(v);
        return (s < 0) ? -s : s;
    endfunction

    function automatic int mag(input logic [7:0] re, input logic [7:0] im);
        int a, b;
        a = abs8(re);
        b = abs8(im);
        return ((a > b) ? a : b) + ((a < b) ? a : b) / 2;
    endfunction

    task automatic push_frame(input int k);
        logic [15:0] fr[4];
        int   n;
        exp_t e;
        fr[0] = f0; fr[1] = f1; fr[2] = f2; fr[3] = f3;
        n = (k == 0) ? 3 : 2;
        for (int bn = 0; bn < 4; bn++) begin
            for (int j = 0; j < n; j++) begin
                if (j == 0) e.d = fr[bn][15:8];
                else if (j == 1) e.d = fr[bn][7:0];
                else e.d = 8'(mag(fr[bn][15:8], fr[bn][7:0]));
                e.b = 2'(bn);
                e.l = (bn == 3) && (j == n - 1);
                if (k == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        m_left[k] = 4 * n;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0; m_left[k] = 0; m_fd[k] = 1'b0;
                m_ovf[k] = 1'b0; stall_v[k] = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic       v, bz, fd, ov, l;
                logic [7:0] d;
                logic [1:0] b;
                bit         hs, lst, was_busy;
                exp_t       e;
                v  = (k == 0) ? sif0.out_valid : sif1.out_valid;
                d  = (k == 0) ? sif0.out_data  : sif1.out_data;
                b  = (k == 0) ? sif0.out_bin   : sif1.out_bin;
                l  = (k == 0) ? sif0.out_last  : sif1.out_last;
                bz = (k == 0) ? busy0 : busy1;
                fd = (k == 0) ? fd0 : fd1;
                ov = (k == 0) ? ovf0 : ovf1;

                chk("out_valid", k, int'(v), int'(m_busy[k]));
                chk("busy", k, int'(bz), int'(m_busy[k]));
                chk("frame_done", k, int'(fd), int'(m_fd[k]));
                chk("overflow_err", k, int'(ov), int'(m_ovf[k]));
                if (stall_v[k]) chk("stall_hold", k, int'({d, b}), int'(stall_d[k]));

                hs = ena && m_busy[k] && out_ready;
                if (hs) begin
                    if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                        chk("byte_unexpected", k, 1, 0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("out_data", k, int'(d), int'(e.d));
                        chk("out_bin", k, int'(b), int'(e.b));
                        chk("out_last", k, int'(l), int'(e.l));
                    end
                end
                stall_v[k] = m_busy[k] && !hs;
                stall_d[k] = {d, b};

                // Advance the model by this cycle's inputs.
                lst      = hs && (m_left[k] == 1);
                was_busy = m_busy[k];
                if (ena) begin
                    m_fd[k] = lst;
                    if (hs) m_left[k]--;
                    if (lst) m_busy[k] = 1'b0;
                    if (done_in && (!was_busy || lst)) begin
                        push_frame(k);
                        m_busy[k] = 1'b1;
                    end
                    if (done_in && was_busy && !lst) m_ovf[k] = 1'b1;
                    else if (clr_err) m_ovf[k] = 1'b0;
                end
            end
        end
    end

    task automatic drive(input bit e, input bit d, input bit r, input bit c);
        ena = e; done_in = d; out_ready = r; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        f0 = a; f1 = b; f2 = c; f3 = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 0, int'(sif0.out_valid), 0);
        chk({tag, "_data"}, 0, int'(sif0.out_data), 0);
        chk({tag, "_bin"}, 0, int'(sif0.out_bin), 0);
        chk({tag, "_last"}, 0, int'(sif0.out_last), 0);
        chk({tag, "_busy"}, 0, int'(busy0), 0);
        chk({tag, "_fd"}, 0, int'(fd0), 0);
        chk({tag, "_ovf"}, 0, int'(ovf0), 0);
        chk({tag, "_valid"}, 1, int'(sif1.out_valid), 0);
        chk({tag, "_data"}, 1, int'(sif1.out_data), 0);
        chk({tag, "_busy"}, 1, int'(busy1), 0);
    endtask

    // Issue done_in exactly on instance k's last-byte handshake.
    task automatic coincide(input int k);
        bit found;
        found = 1'b0;
        set_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_busy[k] && m_left[k] == 1) found = 1'b1;
            else run(1);
        end
        chk("coincide_reached", k, int'(found), 1);
        set_frame(16'hA5C3, 16'h8001, 16'h7F80, 16'h0102);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(14);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Reference frame, ready held high.
        set_frame(16'h05FD, 16'h8080, 16'h7F00, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(14);

        // Ready toggling and ena low mid-frame.
        set_frame(16'hFF81, 16'h4020, 16'hC0E0, 16'h0180);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(2);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        run(14);

        // Dropped frame during byte 5 with ready low, then clear and refill.
        set_frame(16'h2233, 16'h4455, 16'h6677, 16'h8899);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(4);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        f0 = 16'h1111;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(14);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(14);

        // New frame accepted on the last-byte handshake.
        coincide(0);
        coincide(1);

        // Asynchronous reset mid-frame.
        set_frame(16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1010);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(6);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        ena = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_frame(16'h7E81, 16'h0203, 16'h0405, 16'h0607);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(14);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            set_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // Drain and confirm every expected byte was delivered.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("drain_empty", 0, q0.size(), 0);
        chk("drain_empty", 1, q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
